custom_logic_fork: RTL and testbench
====================================

CUSTOM_LOGIC_FORK -- requirements
Module: custom_logic_fork

Interface
REQ-001 The module SHALL have parameter D_WIDTH, default 6, which is the payload width in bits.
REQ-002 The module SHALL have parameter C_WIDTH, default 8, which is the width of the accepted-transfer counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port up_data, input, D_WIDTH bits: upstream payload.
REQ-006 The module SHALL have port up_valid, input, 1 bit: upstream payload valid.
REQ-007 The module SHALL have port up_ready, output, 1 bit: block can accept upstream payload this cycle.
REQ-008 The module SHALL have port down_data_a, output, D_WIDTH bits: branch A payload; it feeds the A-side FIFO of the join path.
REQ-009 The module SHALL have port down_valid_a, output, 1 bit: branch A payload valid.
REQ-010 The module SHALL have port down_ready_a, input, 1 bit: branch A consumer ready.
REQ-011 The module SHALL have port down_data_b, output, D_WIDTH bits: branch B payload.
REQ-012 The module SHALL have port down_valid_b, output, 1 bit: branch B payload valid.
REQ-013 The module SHALL have port down_ready_b, input, 1 bit: branch B consumer ready.
REQ-014 The module SHALL have port xfer_count, output, C_WIDTH bits: count of accepted upstream transfers.

Function
REQ-015 An upstream transfer SHALL occur on any cycle where up_valid and up_ready are both 1; a branch transfer SHALL occur on any cycle where down_valid_x and down_ready_x are both 1.
REQ-016 Each branch SHALL hold one register slot (valid bit plus data); down_valid_x and down_data_x SHALL come directly from that slot, with no combinational path from any input.
REQ-017 up_ready SHALL equal (!down_valid_a | down_ready_a) & (!down_valid_b | down_ready_b); it is combinational on the downstream readies only and never depends on up_valid.
REQ-018 On an upstream transfer, both slots SHALL load up_data and set valid on the next edge, giving a latency of exactly 1 cycle to both branches.
REQ-019 Without an upstream transfer, a slot whose branch transfers SHALL clear its valid bit; a slot that does not transfer SHALL hold its valid bit and data.
REQ-020 Simultaneous branch transfer and upstream transfer in one cycle SHALL reload the slot (valid stays 1), sustaining 1 word per cycle when both branches are always ready.
REQ-021 The branches SHALL drain independently; a word consumed on A SHALL NOT be re-presented on A while B is still pending.
REQ-022 Upstream SHALL stall until both slots are free or freeing.
REQ-023 While down_valid_x=1 and down_ready_x=0, down_data_x SHALL be held stable.
REQ-024 Every payload SHALL be delivered exactly once to each branch, in acceptance order; none dropped or duplicated.
REQ-025 xfer_count SHALL increment by 1 per upstream transfer and wrap from 2^C_WIDTH-1 to 0.
REQ-026 Slot data SHALL be updated only on an upstream transfer, leaving it stable while valid is 0.

Reset
REQ-027 While rst=0, down_valid_a, down_valid_b and xfer_count SHALL be 0 asynchronously.
REQ-028 While rst=0, slot data SHALL be 0.
REQ-029 A word pending in a slot when reset asserts SHALL be discarded and not re-presented.
REQ-030 During and after reset, up_ready SHALL reflect REQ-017 (1 once slots are empty).
REQ-031 The first upstream transfer SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-032 The package hdlgadgets_pkg SHALL hold the default D_WIDTH and C_WIDTH constants, shared with the FIFO and join blocks.
REQ-033 The block SHALL instantiate one sub-module, fork_slot (single-entry valid/data register with load/drain controls), once per branch; the top level SHALL hold only the up_ready logic and the counter.
REQ-034 Target size SHALL be 120-250 RTL lines total.

Verification
REQ-035 Both readies held 1, up_valid held 1 with data 0x01..0x08 -> A and B each receive 0x01..0x08 one cycle later, one word per cycle, up_ready constantly 1, xfer_count=8.
REQ-036 down_ready_b=0, A ready, send 0x15 -> A takes 0x15 at cycle 1; down_valid_a=0 from cycle 2; up_ready=0 until B is ready; raise down_ready_b at cycle 5 -> B takes 0x15, and the next word 0x16 is accepted the same cycle.
REQ-037 Random independent readies and valids, 1000 words -> each branch's output sequence equals the input sequence exactly, and data is stable whenever valid=1 and ready=0.
REQ-038 C_WIDTH=4, 17 transfers -> xfer_count reads 15 after 15 transfers, 0 after 16, 1 after 17.
REQ-039 Both slots valid (0x2A), assert rst for 1 cycle mid-stall -> down_valid_a and down_valid_b drop to 0 immediately, 0x2A is never output, and xfer_count=0.
REQ-040 Chain custom_logic_fork -> FIFO A/B -> join -> FIFO, stimulus 0x00..0x3F -> join output matches its function applied to the pairs (x,x), with no deadlock.

Source files
------------

// File: rtl/hdlgadgets_pkg.sv
// Shared width defaults for the fork, FIFO and join blocks of the hdlgadgets
// stream library.
package hdlgadgets_pkg;

   // Default payload width of one stream word.
   localparam int DEFAULT_D_WIDTH = 6;

   // Default width of the accepted-transfer counter.
   localparam int DEFAULT_C_WIDTH = 8;

   // Number of branches driven by the fork.
   localparam int FORK_BRANCHES = 2;

endpackage : hdlgadgets_pkg

// File: rtl/fork_slot.sv
// Single-entry valid/data register for one fork branch.
// A load wins over a drain, so a word can be replaced in the same cycle that
// the previous one leaves. Data changes only on a load.
module fork_slot
   import hdlgadgets_pkg::*;
#(
   parameter int D_WIDTH = DEFAULT_D_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [D_WIDTH-1:0] load_data,
   input  logic               drain_ready,
   output logic               valid,
   output logic [D_WIDTH-1:0] data
);

   logic               valid_reg;
   logic [D_WIDTH-1:0] data_reg;

   // Valid bit: set on load, cleared when the branch consumes the word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= 1'b1;
      end else if (valid_reg && drain_ready) begin
         valid_reg <= 1'b0;
      end
   end

   // Payload: captured only on load, so it is held while stalled or empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_reg <= '0;
      end else if (load) begin
         data_reg <= load_data;
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;

endmodule : fork_slot

// File: rtl/custom_logic_fork.sv
// Two-way stream fork: every accepted upstream word is delivered once to each
// branch. Each branch owns a one-word register slot and drains independently.
// Upstream is accepted only when both slots are empty or emptying.
module custom_logic_fork
   import hdlgadgets_pkg::*;
#(
   parameter int D_WIDTH = DEFAULT_D_WIDTH,
   parameter int C_WIDTH = DEFAULT_C_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] up_data,
   input  logic               up_valid,
   output logic               up_ready,
   output logic [D_WIDTH-1:0] down_data_a,
   output logic               down_valid_a,
   input  logic               down_ready_a,
   output logic [D_WIDTH-1:0] down_data_b,
   output logic               down_valid_b,
   input  logic               down_ready_b,
   output logic [C_WIDTH-1:0] xfer_count
);

   logic [FORK_BRANCHES-1:0] slot_ready;
   logic [FORK_BRANCHES-1:0] slot_valid;
   logic [FORK_BRANCHES-1:0] slot_free;
   logic [D_WIDTH-1:0]       slot_data [FORK_BRANCHES];
   logic                     up_xfer;
   logic [C_WIDTH-1:0]       count_reg;

   // Branch index 0 is A, index 1 is B.
   assign slot_ready = {down_ready_b, down_ready_a};

   genvar gi;
   generate
      for (gi = 0; gi < FORK_BRANCHES; gi++) begin : g_slot
         fork_slot #(
            .D_WIDTH (D_WIDTH)
         ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .load        (up_xfer),
            .load_data   (up_data),
            .drain_ready (slot_ready[gi]),
            .valid       (slot_valid[gi]),
            .data        (slot_data[gi])
         );
         // A slot can take a new word if it is empty or its word leaves now.
         assign slot_free[gi] = !slot_valid[gi] || slot_ready[gi];
      end
   endgenerate

   // Ready depends only on slot state and downstream readies, never on up_valid.
   assign up_ready = &slot_free;
   assign up_xfer  = up_valid && up_ready;

   // Accepted-transfer counter, wrapping naturally at its width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (up_xfer) begin
         count_reg <= count_reg + C_WIDTH'(1);
      end
   end

   assign down_valid_a = slot_valid[0];
   assign down_data_a  = slot_data[0];
   assign down_valid_b = slot_valid[1];
   assign down_data_b  = slot_data[1];
   assign xfer_count   = count_reg;

endmodule : custom_logic_fork

// File: tb/tb_custom_logic_fork.sv
// Scoreboard bench for custom_logic_fork: accepted words are pushed to one
// queue per branch and popped when that branch consumes a word.
module tb_custom_logic_fork;

   localparam int DW = 6;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] up_data = '0;
   logic          up_valid = 1'b0;
   logic          up_ready;
   logic [DW-1:0] down_data_a, down_data_b;
   logic          down_valid_a, down_valid_b;
   logic          down_ready_a = 1'b0;
   logic          down_ready_b = 1'b0;
   logic [CW-1:0] xfer_count;

   // Narrow-counter instance used for the wrap test.
   logic [DW-1:0] up_data4 = '0;
   logic          up_valid4 = 1'b0;
   logic          up_ready4;
   logic [DW-1:0] down_data_a4, down_data_b4;
   logic          down_valid_a4, down_valid_b4;
   logic [3:0]    xfer_count4;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] q_a[$];
   logic [DW-1:0] q_b[$];
   logic [CW-1:0] exp_count = '0;
   logic          mon_en = 1'b0;
   logic          accepted = 1'b0;
   logic          hold_a = 1'b0, hold_b = 1'b0;
   logic [DW-1:0] prev_a = '0, prev_b = '0;
   int            words = 0;

   always #5 clk = ~clk;

   custom_logic_fork #(.D_WIDTH(DW), .C_WIDTH(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .up_data      (up_data),
      .up_valid     (up_valid),
      .up_ready     (up_ready),
      .down_data_a  (down_data_a),
      .down_valid_a (down_valid_a),
      .down_ready_a (down_ready_a),
      .down_data_b  (down_data_b),
      .down_valid_b (down_valid_b),
      .down_ready_b (down_ready_b),
      .xfer_count   (xfer_count)
   );

   custom_logic_fork #(.D_WIDTH(DW), .C_WIDTH(4)) dut4 (
      .clk          (clk),
      .rst          (rst),
      .up_data      (up_data4),
      .up_valid     (up_valid4),
      .up_ready     (up_ready4),
      .down_data_a  (down_data_a4),
      .down_valid_a (down_valid_a4),
      .down_ready_a (1'b1),
      .down_data_b  (down_data_b4),
      .down_valid_b (down_valid_b4),
      .down_ready_b (1'b1),
      .xfer_count   (xfer_count4)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_model();
      q_a.delete();
      q_b.delete();
      exp_count = '0;
      hold_a = 1'b0;
      hold_b = 1'b0;
      accepted = 1'b0;
   endtask

   // Monitor away from the active edge: compare against the model, then update it.
   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_rdy;
         exp_rdy = (q_a.size() == 0 || down_ready_a) && (q_b.size() == 0 || down_ready_b);
         check_eq("valid_a", 32'(down_valid_a), 32'(q_a.size() != 0));
         check_eq("valid_b", 32'(down_valid_b), 32'(q_b.size() != 0));
         if (hold_a) check_eq("hold_a", 32'(down_data_a), 32'(prev_a));
         if (hold_b) check_eq("hold_b", 32'(down_data_b), 32'(prev_b));
         check_eq("up_ready", 32'(up_ready), 32'(exp_rdy));
         check_eq("count", 32'(xfer_count), 32'(exp_count));
         if (q_a.size() > 0 && down_ready_a) check_eq("data_a", 32'(down_data_a), 32'(q_a.pop_front()));
         if (q_b.size() > 0 && down_ready_b) check_eq("data_b", 32'(down_data_b), 32'(q_b.pop_front()));
         hold_a = down_valid_a && !down_ready_a;
         hold_b = down_valid_b && !down_ready_b;
         prev_a = down_data_a;
         prev_b = down_data_b;
         if (up_valid && exp_rdy) begin
            q_a.push_back(up_data);
            q_b.push_back(up_data);
            exp_count = exp_count + 1'b1;
            accepted = 1'b1;
            words++;
            $display("xfer %0d: data=0x%02h", words, up_data);
         end else begin
            accepted = 1'b0;
         end
      end
   end

   initial begin
      int sent;
      int cyc;
      logic [DW-1:0] cur;

      // Reset state.
      #1;
      check_eq("rst_valid_a", 32'(down_valid_a), 32'd0);
      check_eq("rst_valid_b", 32'(down_valid_b), 32'd0);
      check_eq("rst_count", 32'(xfer_count), 32'd0);
      check_eq("rst_up_ready", 32'(up_ready), 32'd1);
      check_eq("rst_data_a", 32'(down_data_a), 32'd0);

      // Full-rate stream 0x01..0x08, first word on the first edge after release.
      #7;
      rst = 1'b1;
      mon_en = 1'b1;
      down_ready_a = 1'b1;
      down_ready_b = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         up_data = DW'(i);
         up_valid = 1'b1;
         @(posedge clk); #1;
      end
      up_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("stream_count", 32'(xfer_count), 32'd8);

      // B stalls while A drains 0x15; 0x16 accepted when B finally takes 0x15.
      down_ready_b = 1'b0;
      up_data = 6'h15;
      up_valid = 1'b1;
      @(posedge clk); #1;
      up_data = 6'h16;
      repeat (3) @(posedge clk);
      #1;
      check_eq("stall_up_ready", 32'(up_ready), 32'd0);
      check_eq("stall_valid_a", 32'(down_valid_a), 32'd0);
      down_ready_b = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!accepted && cyc < 10);
      check_eq("stall_accept_16", 32'(accepted), 32'd1);
      up_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Random valids and readies, 1000 words.
      sent = 0;
      cyc = 0;
      cur = DW'($urandom);
      accepted = 1'b0;
      while (sent < 1000 && cyc < 20000) begin
         @(posedge clk); #1;
         if (accepted) begin
            sent++;
            cur = DW'($urandom);
         end
         up_valid = (sent < 1000) && ($urandom_range(3) != 0);
         up_data = up_valid ? cur : DW'($urandom);
         down_ready_a = ($urandom_range(9) < 7);
         down_ready_b = ($urandom_range(9) < 7);
         cyc++;
      end
      check_eq("random_done", 32'(sent), 32'd1000);
      up_valid = 1'b0;
      down_ready_a = 1'b1;
      down_ready_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("drain_q_a", 32'(q_a.size()), 32'd0);
      check_eq("drain_q_b", 32'(q_b.size()), 32'd0);

      // Reset mid-stall with 0x2A pending in both slots.
      down_ready_a = 1'b0;
      down_ready_b = 1'b0;
      up_data = 6'h2A;
      up_valid = 1'b1;
      @(posedge clk); #1;
      up_valid = 1'b0;
      @(posedge clk); #2;
      mon_en = 1'b0;
      rst = 1'b0;
      #1;
      check_eq("mid_rst_valid_a", 32'(down_valid_a), 32'd0);
      check_eq("mid_rst_valid_b", 32'(down_valid_b), 32'd0);
      check_eq("mid_rst_count", 32'(xfer_count), 32'd0);
      check_eq("mid_rst_up_ready", 32'(up_ready), 32'd1);
      clear_model();
      @(posedge clk); #2;
      rst = 1'b1;
      mon_en = 1'b1;
      down_ready_a = 1'b1;
      down_ready_b = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Counter wrap on a 4-bit counter.
      up_valid4 = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         up_data4 = DW'(k);
         @(posedge clk); #1;
         if (k == 15) check_eq("wrap_15", 32'(xfer_count4), 32'd15);
         if (k == 16) check_eq("wrap_16", 32'(xfer_count4), 32'd0);
         if (k == 17) check_eq("wrap_17", 32'(xfer_count4), 32'd1);
      end
      up_valid4 = 1'b0;
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_custom_logic_fork
